fetch_queue: RTL

- Parametrised instruction-fetch front end that decouples the instruction-bus port from decode with a DEPTH-entry circular instruction queue.
- Sits between the instruction bus (PC address/data/ready) and the if/id pipeline register.
- Keeps a sequential fetch PC, redirects and flushes on an ex-stage jump, and honours a pipeline hold.
- Generalises the single-entry fetch path with configurable depth, widths, reset vector and an optional zero-latency bypass.

---
 rtl/fetch_queue.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue
//
// Instruction-fetch front end. It keeps a sequential fetch PC and requests
// instructions from the instruction bus. A DEPTH-entry circular queue of
// {pc, instr} pairs sits between the bus and the if/id register, so bus
// stalls and decode stalls do not block each other. An ex-stage jump flushes
// the queue and redirects the fetch PC. A pipeline hold stops new requests,
// but entries that are already queued still drain to decode.
//
// Parameters:
//   ADDR_W   - instruction address width
//   INSTR_W  - instruction word width
//   DEPTH    - queue entries (power of two, >= 2)
//   RESET_PC - fetch PC after reset
//
// Ports:
//   clk_i, rst_i    - clock and synchronous active-high reset
//   instr_req_o     - fetch request to the instruction bus
//   instr_addr_o    - word-aligned fetch address
//   instr_data_i    - fetched instruction, valid when instr_ready_i=1
//   instr_ready_i   - bus completes the current request this cycle
//   jump_flag_i     - redirect and flush
//   jump_addr_i     - redirect target (bits [1:0] are ignored)
//   hold_i          - suppress new fetch requests
//   valid_o         - queue head valid to decode
//   instr_o, pc_o   - head instruction and its PC
//   ready_i         - decode accepts the head this cycle
//   count_o         - current occupancy
//
// Optional feature macro: FETCHQ_BYPASS_EN
//   When it is defined, a response that arrives while the queue is empty is
//   presented to decode in the same cycle. If decode accepts it in that cycle,
//   the response is never written into the queue.

module fetch_queue #(
   parameter int                ADDR_W   = 32,
   parameter int                INSTR_W  = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   output logic                     instr_req_o,
   output logic [ADDR_W-1:0]        instr_addr_o,
   input  logic [INSTR_W-1:0]       instr_data_i,
   input  logic                     instr_ready_i,
   input  logic                     jump_flag_i,
   input  logic [ADDR_W-1:0]        jump_addr_i,
   input  logic                     hold_i,
   output logic                     valid_o,
   output logic [INSTR_W-1:0]       instr_o,
   output logic [ADDR_W-1:0]        pc_o,
   input  logic                     ready_i,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);

   logic [ADDR_W-1:0]  pc_mem    [DEPTH];
   logic [INSTR_W-1:0] instr_mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   count;
   logic [ADDR_W-1:0]  fetch_pc;

   logic empty;
   logic req;
   logic push;
   logic pop_q;
   logic write_en;

   assign empty = (count == '0);
   assign req   = !rst_i && !hold_i && !jump_flag_i && (count != FULL_COUNT);
   assign push  = req && instr_ready_i;

   // The fetch PC is always stored word-aligned, so it drives the bus directly.
   assign instr_req_o  = req;
   assign instr_addr_o = fetch_pc;
   assign count_o      = rst_i ? '0 : count;

   // A queue pop only happens when the queue has something in it. A bypassed
   // response is consumed without ever touching the queue.
   assign pop_q = !rst_i && !empty && ready_i;

`ifdef FETCHQ_BYPASS_EN
   logic bypass;

   // push already excludes reset and jump, so a flush also suppresses the bypass.
   assign bypass   = empty && push;
   assign valid_o  = !rst_i && (!empty || bypass);
   assign instr_o  = bypass ? instr_data_i : instr_mem[rd_ptr];
   assign pc_o     = bypass ? fetch_pc     : pc_mem[rd_ptr];
   assign write_en = push && !(bypass && ready_i);
`else
   assign valid_o  = !rst_i && !empty;
   assign instr_o  = instr_mem[rd_ptr];
   assign pc_o     = pc_mem[rd_ptr];
   assign write_en = push;
`endif

   // Queue storage has no reset. Occupancy alone decides which entries are live.
   always_ff @(posedge clk_i) begin
      if (write_en) begin
         pc_mem[wr_ptr]    <= fetch_pc;
         instr_mem[wr_ptr] <= instr_data_i;
      end
   end

   // Control state. A jump outranks any same-cycle response or pop. The
   // fetch PC advances on every accepted response, including a bypassed one.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc <= RESET_PC & WORD_MASK;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (jump_flag_i) begin
         fetch_pc <= jump_addr_i & WORD_MASK;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            fetch_pc <= fetch_pc + ADDR_W'(4);
         end
         if (write_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_q) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({write_en, pop_q})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
